// File: rtl/illegal_instruction_exception_sequencer.sv
// Turns an illegal-instruction flag from decode into one precise exception request.
// Blocks issue from detection until the flush that follows the accepted request.
module illegal_instruction_exception_sequencer #(
  parameter int ID_W    = 3,
  parameter int COUNT_W = 16,
  parameter bit TVAL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               decode_valid,
  input  logic [31:0]        decode_instruction,
  input  logic [31:0]        decode_pc,
  input  logic [ID_W-1:0]    decode_id,
  input  logic               illegal_instruction,
  input  logic               older_in_flight,
  input  logic               exception_ack,
  input  logic               flush,
  output logic               issue_block,
  output logic               exception_valid,
  output logic [4:0]         exception_code,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_tval,
  output logic [ID_W-1:0]    exception_id,
  output logic [COUNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_WAIT_FLUSH
  } state_t;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;

  state_t state;
  logic   capture;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  function automatic logic [31:0] tval_sel(input logic [31:0] instr);
    return TVAL_EN ? instr : 32'd0;
  endfunction

  // A flush in the detection cycle means an older instruction redirected; drop it.
  assign capture     = decode_valid & illegal_instruction & ~flush;
  assign issue_block = (state != S_IDLE) | (decode_valid & illegal_instruction);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      exception_valid <= 1'b0;
      exception_code  <= 5'd0;
      exception_pc    <= 32'd0;
      exception_tval  <= 32'd0;
      exception_id    <= '0;
      illegal_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (capture) begin
            exception_pc   <= decode_pc;
            exception_tval <= tval_sel(decode_instruction);
            exception_id   <= decode_id;
            state          <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (!older_in_flight) begin
            state           <= S_REQ;
            exception_valid <= 1'b1;
            exception_code  <= CAUSE_ILLEGAL;
          end
        end
        S_REQ: begin
          // Ack beats a coincident flush: the exception unit already committed to it.
          if (exception_ack) begin
            state           <= S_WAIT_FLUSH;
            exception_valid <= 1'b0;
            exception_code  <= 5'd0;
            illegal_count   <= sat_inc(illegal_count);
          end else if (flush) begin
            state           <= S_IDLE;
            exception_valid <= 1'b0;
            exception_code  <= 5'd0;
          end
        end
        S_WAIT_FLUSH: begin
          if (flush) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state           <= S_IDLE;
          exception_valid <= 1'b0;
          exception_code  <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_illegal_instruction_exception_sequencer.sv
// Three sequencer configurations share one stimulus stream; each is scored against its own reference.
module tb_illegal_instruction_exception_sequencer;

  logic        clk;
  logic        rst_n;
  logic        dv;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  id;
  logic        il;
  logic        older;
  logic        ack;
  logic        fl;

  logic        ib  [3];
  logic        ev  [3];
  logic [4:0]  ec  [3];
  logic [31:0] epc [3];
  logic [31:0] etv [3];
  logic [2:0]  eid [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tval;
    logic [2:0]  id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t cur [3];
  bit   prev_ev [3];

  // Reference: a pending fault, whether it has been requested, whether it was taken.
  bit          m_pend  [3];
  bit          m_req   [3];
  bit          m_taken [3];
  logic [31:0] m_pc    [3];
  logic [31:0] m_tval  [3];
  logic [2:0]  m_id    [3];
  int          m_cnt   [3];
  int          cnt_max [3] = '{65535, 65535, 3};
  bit          tval_en [3] = '{1'b1, 1'b0, 1'b1};

  illegal_instruction_exception_sequencer #(.ID_W(3), .COUNT_W(16), .TVAL_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .decode_valid(dv), .decode_instruction(instr), .decode_pc(pc),
    .decode_id(id), .illegal_instruction(il), .older_in_flight(older), .exception_ack(ack),
    .flush(fl), .issue_block(ib[0]), .exception_valid(ev[0]), .exception_code(ec[0]),
    .exception_pc(epc[0]), .exception_tval(etv[0]), .exception_id(eid[0]), .illegal_count(cnt0));

  illegal_instruction_exception_sequencer #(.ID_W(3), .COUNT_W(16), .TVAL_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .decode_valid(dv), .decode_instruction(instr), .decode_pc(pc),
    .decode_id(id), .illegal_instruction(il), .older_in_flight(older), .exception_ack(ack),
    .flush(fl), .issue_block(ib[1]), .exception_valid(ev[1]), .exception_code(ec[1]),
    .exception_pc(epc[1]), .exception_tval(etv[1]), .exception_id(eid[1]), .illegal_count(cnt1));

  illegal_instruction_exception_sequencer #(.ID_W(3), .COUNT_W(2), .TVAL_EN(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .decode_valid(dv), .decode_instruction(instr), .decode_pc(pc),
    .decode_id(id), .illegal_instruction(il), .older_in_flight(older), .exception_ack(ack),
    .flush(fl), .issue_block(ib[2]), .exception_valid(ev[2]), .exception_code(ec[2]),
    .exception_pc(epc[2]), .exception_tval(etv[2]), .exception_id(eid[2]), .illegal_count(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{pc: 32'd0, tval: 32'd0, id: 3'd0};
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic reset_models();
    for (int k = 0; k < 3; k++) begin
      m_pend[k]  = 1'b0;
      m_req[k]   = 1'b0;
      m_taken[k] = 1'b0;
      m_cnt[k]   = 0;
      prev_ev[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic model_step(input int k);
    exp_t e;
    if (!m_pend[k]) begin
      if (dv && il && !fl) begin
        m_pend[k] = 1'b1;
        m_pc[k]   = pc;
        m_id[k]   = id;
        m_tval[k] = tval_en[k] ? instr : 32'd0;
      end
    end else if (!m_req[k]) begin
      if (fl) m_pend[k] = 1'b0;
      else if (!older) begin
        m_req[k] = 1'b1;
        e = '{pc: m_pc[k], tval: m_tval[k], id: m_id[k]};
        sb_push(k, e);
      end
    end else if (!m_taken[k]) begin
      if (ack) begin
        m_taken[k] = 1'b1;
        if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end else if (fl) begin
        m_pend[k] = 1'b0;
        m_req[k]  = 1'b0;
      end
    end else if (fl) begin
      m_pend[k]  = 1'b0;
      m_req[k]   = 1'b0;
      m_taken[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic idle_inputs();
    dv = 1'b0; il = 1'b0; fl = 1'b0; ack = 1'b0; older = 1'b0;
  endtask

  // Monitor: scores every output each cycle and pops the scoreboard when a request appears.
  initial begin
    exp_t e;
    bit   ok;
    bit   exp_v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          exp_v = m_pend[k] && m_req[k] && !m_taken[k];
          chk("valid", k, 32'(ev[k]), 32'(exp_v));
          chk("code", k, 32'(ec[k]), exp_v ? 32'd2 : 32'd0);
          chk("count", k, get_cnt(k), 32'(m_cnt[k]));
          chk("issue_block", k, 32'(ib[k]), 32'(m_pend[k] || (dv && il)));
          if (ev[k] && !prev_ev[k]) begin
            sb_pop(k, e, ok);
            chk("sb_nonempty", k, 32'(ok), 32'd1);
            if (ok) begin
              chk("req_pc", k, epc[k], e.pc);
              chk("req_tval", k, etv[k], e.tval);
              chk("req_id", k, 32'(eid[k]), 32'(e.id));
              cur[k] = e;
            end
          end else if (ev[k]) begin
            chk("hold_pc", k, epc[k], cur[k].pc);
            chk("hold_tval", k, etv[k], cur[k].tval);
            chk("hold_id", k, 32'(eid[k]), 32'(cur[k].id));
          end
          prev_ev[k] = ev[k];
        end
      end
    end
  end

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (ev[0]) break;
      step();
    end
    chk("wait_valid_timeout", 0, 32'(ev[0]), 32'd1);
  endtask

  task automatic run_fault(input logic [31:0] f_pc, input logic [31:0] f_instr, input logic [2:0] f_id,
                           input int older_n, input bit abort, input bit ack_flush);
    dv = 1'b1; il = 1'b1; pc = f_pc; instr = f_instr; id = f_id; older = (older_n > 0);
    step();
    dv = 1'b0; il = 1'b0;
    if (abort) begin
      fl = 1'b1;
      step();
      fl = 1'b0; older = 1'b0; dv = 1'b1; il = 1'b0; pc = f_pc + 32'd4;
      step();
      idle_inputs();
      step();
      return;
    end
    for (int i = 1; i < older_n; i++) step();
    older = 1'b0;
    if (older_n == 0) begin
      step();
      chk("latency_n2", 0, 32'(ev[0]), 32'd1);
    end
    wait_valid();
    step();
    ack = 1'b1; fl = ack_flush;
    step();
    ack = 1'b0; fl = 1'b0;
    step();
    step();
    fl = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    pc = 32'd0; instr = 32'd0; id = 3'd0;
    idle_inputs();
    reset_models();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 32'(ev[k]), 32'd0);
      chk("rst_code", k, 32'(ec[k]), 32'd0);
      chk("rst_pc", k, epc[k], 32'd0);
      chk("rst_tval", k, etv[k], 32'd0);
      chk("rst_id", k, 32'(eid[k]), 32'd0);
      chk("rst_count", k, get_cnt(k), 32'd0);
    end
    rst_n = 1'b1;
    step();

    run_fault(32'h8000_0100, 32'hFFFF_FFFF, 3'd5, 0, 1'b0, 1'b0);
    run_fault(32'h8000_0200, 32'h1234_5678, 3'd3, 5, 1'b0, 1'b0);
    run_fault(32'h8000_0300, 32'hDEAD_BEEF, 3'd2, 2, 1'b1, 1'b0);

    dv = 1'b1; il = 1'b1; fl = 1'b1; pc = 32'h8000_0400; instr = 32'h0BAD_0BAD; id = 3'd6;
    step();
    idle_inputs();
    repeat (4) step();
    chk("flush_beats_capture", 0, 32'(ev[0]), 32'd0);

    run_fault(32'h8000_0500, 32'h0000_707F, 3'd1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      run_fault($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, 1'b0);
    chk("saturated", 2, get_cnt(2), 32'd3);

    dv = 1'b1; il = 1'b1; pc = 32'h8000_0600; instr = 32'h0000_0000; id = 3'd7;
    step();
    idle_inputs();
    wait_valid();
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_rst_valid", k, 32'(ev[k]), 32'd0);
      chk("async_rst_count", k, get_cnt(k), 32'd0);
      chk("async_rst_pc", k, epc[k], 32'd0);
    end
    reset_models();
    #2;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 1500; i++) begin
      dv    = 1'($urandom_range(0, 1));
      il    = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 7) == 0);
      older = 1'($urandom_range(0, 1));
      ack   = 1'($urandom_range(0, 1));
      pc    = $urandom;
      instr = $urandom;
      id    = 3'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    step();
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("sb_drained", k, 32'(sb_size(k)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
